// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-lite signal bundle for the register-file slave; master drives requests,
// slave drives ready/response signals.
interface axi_lite_slave_regfile_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned ID_SIZE   = 32
);
  logic                 awvalid;
  logic                 awready;
  logic [ADDR_SIZE-1:0] awaddr;
  logic [ID_SIZE-1:0]   awid;
  logic                 awsize;
  logic                 wvalid;
  logic                 wready;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wlast;
  logic                 bvalid;
  logic                 bready;
  logic                 bresp;
  logic [ID_SIZE-1:0]   bid;
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_SIZE-1:0] araddr;
  logic [ID_SIZE-1:0]   arid;
  logic                 arsize;
  logic                 rvalid;
  logic                 rready;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rlast;
  logic [ID_SIZE-1:0]   rid;
  logic                 rresp;

  modport master (
    output awvalid, awaddr, awid, awsize, wvalid, wdata, wlast, bready,
           arvalid, araddr, arid, arsize, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rlast, rid, rresp
  );

  modport slave (
    input  awvalid, awaddr, awid, awsize, wvalid, wdata, wlast, bready,
           arvalid, araddr, arid, arsize, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rlast, rid, rresp
  );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-lite slave register bank with independent write and read FSMs.
// Define AXIL_REGFILE_ADDR_CHECK_EN to reject misaligned/out-of-range addresses.
module axi_lite_slave_regfile #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          ID_SIZE   = 32,
  parameter int unsigned          NUM_REGS  = 16,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
  input logic                     clk,
  input logic                     reset_n,
  axi_lite_slave_regfile_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic [0:0] {RdIdle, RdData} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  // Holds both ready signals low for the first cycle after reset.
  logic live_q;

  logic [DATA_SIZE-1:0] regs_q [NUM_REGS];
  logic [IdxW-1:0]      aw_idx_q;
  logic                 aw_err_q;
  logic [ID_SIZE-1:0]   awid_q;
  logic [DATA_SIZE-1:0] rdata_q;
  logic [ID_SIZE-1:0]   rid_q;
  logic                 rresp_q;

  logic [ADDR_SIZE-1:0] aw_off, ar_off;
  logic [IdxW-1:0]      aw_idx, ar_idx;
  logic                 aw_err, ar_err;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                 unused_ok;

  assign unused_ok = ^{bus.awsize, bus.arsize, bus.wlast};

  assign aw_off = bus.awaddr - BASE_ADDR;
  assign ar_off = bus.araddr - BASE_ADDR;
  assign aw_idx = aw_off[2 +: IdxW];
  assign ar_idx = ar_off[2 +: IdxW];

`ifdef AXIL_REGFILE_ADDR_CHECK_EN
  localparam logic [ADDR_SIZE:0] AddrLim = {1'b0, BASE_ADDR} + (ADDR_SIZE+1)'(4 * NUM_REGS);
  assign aw_err = (bus.awaddr < BASE_ADDR) || ({1'b0, bus.awaddr} >= AddrLim)
                  || (bus.awaddr[1:0] != 2'b00);
  assign ar_err = (bus.araddr < BASE_ADDR) || ({1'b0, bus.araddr} >= AddrLim)
                  || (bus.araddr[1:0] != 2'b00);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;

  always_comb begin
    wr_state_d  = wr_state_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        bus.awready = live_q;
        if (bus.awvalid && live_q) wr_state_d = WrData;
      end
      WrData: begin
        bus.wready = 1'b1;
        if (bus.wvalid) wr_state_d = WrResp;
      end
      WrResp: begin
        bus.bvalid = 1'b1;
        if (bus.bready) wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  assign bus.bid   = bus.bvalid ? awid_q   : '0;
  assign bus.bresp = bus.bvalid ? aw_err_q : 1'b0;

  always_comb begin
    rd_state_d  = rd_state_q;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        bus.arready = live_q;
        if (bus.arvalid && live_q) rd_state_d = RdData;
      end
      RdData: begin
        bus.rvalid = 1'b1;
        if (bus.rready) rd_state_d = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  assign bus.rlast = bus.rvalid;
  assign bus.rdata = rdata_q;
  assign bus.rid   = rid_q;
  assign bus.rresp = rresp_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      live_q     <= 1'b0;
      aw_idx_q   <= '0;
      aw_err_q   <= 1'b0;
      awid_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      live_q     <= 1'b1;
      if (aw_hs) begin
        aw_idx_q <= aw_idx;
        aw_err_q <= aw_err;
        awid_q   <= bus.awid;
      end
    end
  end

  // Read capture uses the pre-write register value when W lands on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rid_q   <= '0;
      rresp_q <= 1'b0;
    end else if (ar_hs) begin
      rdata_q <= ar_err ? '0 : regs_q[ar_idx];
      rid_q   <= bus.arid;
      rresp_q <= ar_err;
    end else if (r_hs) begin
      rdata_q <= '0;
      rid_q   <= '0;
      rresp_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (w_hs && !aw_err_q) begin
      regs_q[aw_idx_q] <= bus.wdata;
    end
  end
endmodule
